// File: rtl/pmem_line_responder_pkg.sv
// Shared constants, state encoding and beat index type for the pmem line responder.
package pmem_line_responder_pkg;
  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int OFFSET_W   = 5;
  localparam int BEAT_IDX_W = $clog2(BEATS);

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } pmem_state_e;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache-line side and memory-burst side signals of the pmem line responder.
interface pmem_line_responder_if;
  import pmem_line_responder_pkg::*;

  logic              line_read;
  logic              line_write;
  logic [31:0]       line_address;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;

  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_address;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport master (
    output line_read, line_write, line_address, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_read, burst_write, burst_address, burst_wdata
  );

  modport slave (
    input  line_read, line_write, line_address, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/pmem_line_responder_line_beat_buffer.sv
// Line storage: a fill register assembled beat by beat, and a writeback register
// loaded whole and read out beat by beat.
module line_beat_buffer
  import pmem_line_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              fill_we,
  input  beat_idx_t         beat_idx,
  input  logic [BEAT_W-1:0] fill_beat,
  output logic [LINE_W-1:0] fill_line,
  output logic [BEAT_W-1:0] wb_beat
);
  logic [LINE_W-1:0] wb_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_line <= '0;
      wb_line   <= '0;
    end else begin
      if (load)
        wb_line <= load_line;
      if (fill_we)
        fill_line[BEAT_W*int'(beat_idx) +: BEAT_W] <= fill_beat;
    end
  end

  assign wb_beat = wb_line[BEAT_W*int'(beat_idx) +: BEAT_W];
endmodule

// File: rtl/pmem_line_responder.sv
// Serialises 256-bit cache line reads/writes into 64-bit memory bursts.
// Optional build macro PMEM_PERF_CNT_EN adds read/write line and wait-cycle counters.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  pmem_line_responder_if.slave   bus
`ifdef PMEM_PERF_CNT_EN
  ,
  output logic [31:0]            perf_rd_lines,
  output logic [31:0]            perf_wr_lines,
  output logic [31:0]            perf_wait_cycles
`endif
);
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  pmem_state_e       state, state_nxt;
  beat_idx_t         beat, beat_nxt;
  logic [31:0]       addr_q;
  logic              wb_load, fill_we;
  logic [BEAT_W-1:0] wb_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (state == IDLE && (bus.line_read || bus.line_write))
        addr_q <= line_align(bus.line_address);
    end
  end

  // Write wins a simultaneous request; the held read is picked up on the next IDLE.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    wb_load   = 1'b0;
    fill_we   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.line_write) begin
          state_nxt = WR_BURST;
          wb_load   = 1'b1;
        end else if (bus.line_read) begin
          state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        if (bus.burst_resp) begin
          fill_we  = 1'b1;
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT)
            state_nxt = DONE;
        end
      end
      WR_BURST: begin
        if (bus.burst_resp) begin
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT)
            state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wb_load),
    .load_line (bus.line_wdata),
    .fill_we   (fill_we),
    .beat_idx  (beat),
    .fill_beat (bus.burst_rdata),
    .fill_line (bus.line_rdata),
    .wb_beat   (wb_beat)
  );

  assign bus.burst_read    = (state == RD_BURST);
  assign bus.burst_write   = (state == WR_BURST);
  assign bus.line_resp     = (state == DONE);
  assign bus.burst_address = addr_q;
  assign bus.burst_wdata   = (state == WR_BURST) ? wb_beat : '0;

`ifdef PMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_lines    <= '0;
      perf_wr_lines    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state == RD_BURST && state_nxt == DONE)
        perf_rd_lines <= perf_rd_lines + 32'd1;
      if (state == WR_BURST && state_nxt == DONE)
        perf_wr_lines <= perf_wr_lines + 32'd1;
      if ((state == RD_BURST || state == WR_BURST) && !bus.burst_resp)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif
endmodule
